rr_mux4_arbiter: RTL
====================

// Module: rr_mux4_arbiter
// PURPOSE
//  Shares one WIDTH-bit output channel between four valid/ready requesters.
//  Round-robin arbitration drives the select of a 4:1 datapath mux.
//  The winner's data goes into a single registered output slot.
//  Sits ahead of any single-consumer resource that is fed by four producers.
// PARAMETERS
//  WIDTH  8  payload width of every input/output data bus
// PORTS
//  clock         in   1        single clock; all state on rising edge
//  reset         in   1        asynchronous, active-high; clears all state immediately
//  io_in_valid   in   4        per-requester valid, bit i = requester i
//  io_in_data    in   4*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//  io_in_ready   out  4        one-hot-or-zero; bit i high = requester i accepted this cycle
//  io_out_valid  out  1        output slot holds a beat
//  io_out_data   out  WIDTH    output slot payload
//  io_out_ready  in   1        consumer accepts the beat when high with io_out_valid
//  io_selector   out  2        index of the current grant (mux select, combinational)
//  io_grant_idx  out  2        requester index of the beat held in the output slot
// BEHAVIOUR
//  Reset values
//   - io_out_valid=0, io_out_data=0, io_grant_idx=0.
//   - Round-robin pointer last=3, so requester 0 has top priority first.
//  Slot free: free = !io_out_valid | io_out_ready (the slot drains or is empty this cycle).
//  Grant (combinational)
//   - Search io_in_valid starting at (last+1) mod 4 and moving upward with wrap.
//   - The first set bit wins, giving index g. io_selector=g.
//   - If no request is valid, io_selector=last+1 mod 4 and no grant is made.
//  Ready: io_in_ready[g] = free & io_in_valid[g]; every other bit is 0.
//  Accept (edge where io_in_ready[g]=1)
//   - out_data<=in_data[g]; io_grant_idx<=g; io_out_valid<=1; last<=g.
//  Drain only (io_out_valid & io_out_ready, no accept): io_out_valid<=0.
//  Simultaneous drain and accept: the new beat replaces the old one in the same edge.
//   - Full throughput: 1 beat/cycle.
//  Stall (io_out_valid & !io_out_ready)
//   - io_out_data, io_grant_idx and last stay stable.
//   - All io_in_ready are 0.
//  Latency: an input is accepted at edge N and is visible at the output after edge N.
//   - Output has 1-cycle latency and no combinational in->out data path.
//   - io_in_ready does depend combinationally on io_out_ready.
//  Fairness
//   - With all four requesters continuously valid and io_out_ready=1, grants go 0,1,2,3,0,...
//   - A requester waits at most 3 accepted beats.
//  Requester i deasserts valid before it is granted: no transfer for i, and the pointer is unaffected.
//  Reset mid-operation: any held beat is dropped, io_out_valid falls immediately, and the pointer returns to 3.
//  No states beyond last[1:0], the slot registers and io_out_valid; no FSM encoding is needed.
// STRUCTURE
//  Shared package holds:
//   - localparam NUM_REQ=4, SEL_W=2;
//   - function rr_pick(valid[3:0], last[1:0]) -> {found, idx[1:0]}.
//  Sub-module mux4_w #(WIDTH): a 4:1 WIDTH-bit mux, sel=io_selector.
//   - Built as two levels of 2:1 muxes: sel[0] picks within pairs {0,1}/{2,3}, sel[1] picks between the pairs.
//  Top level holds the pointer register, the output slot registers and the ready logic.
// TESTING
//  1. Reset with all valid=0 -> io_out_valid=0, io_in_ready=0000, io_selector=0.
//  2. Only requester 2 valid, data 0xA5, out_ready=1
//     -> in_ready=0100; next cycle out_valid=1, out_data=0xA5, grant_idx=2.
//  3. All four valid, data 0x10,0x11,0x12,0x13, out_ready=1 for 8 cycles
//     -> out_data sequence 10,11,12,13,10,11,12,13, one beat per cycle.
//  4. Slot holds 0x11 with out_ready=0 for 3 cycles, all valid
//     -> out_data stays 0x11, in_ready=0000.
//     Then raise out_ready -> requester 2 is granted next.
//  5. last=1 with only requesters 0 and 3 valid -> 3 is granted before 0 (wrap order 2,3,0).
//  6. Assert reset while out_valid=1, mid-stream
//     -> out_valid=0 with no clock edge needed.
//     Release reset with all valid -> requester 0 is granted first.

Source files
------------

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared constants and the round-robin pick function for the four-requester arbiter.
package rr_mux4_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // Returns {found, idx}; the search starts one past the last winner and wraps.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [SEL_W-1:0]   last);
        logic [SEL_W-1:0] idx;
        logic [SEL_W:0]   res;
        res = {1'b0, last + 2'd1};
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!res[SEL_W] && valid[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4_w.sv
// 4:1 WIDTH-bit datapath mux built from two levels of 2:1 muxes.
module mux4_w
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_REQ*WIDTH-1:0] data,
    output logic [WIDTH-1:0]         y
);

    logic [WIDTH-1:0] pair_lo;
    logic [WIDTH-1:0] pair_hi;

    assign pair_lo = sel[0] ? data[1*WIDTH +: WIDTH] : data[0*WIDTH +: WIDTH];
    assign pair_hi = sel[0] ? data[3*WIDTH +: WIDTH] : data[2*WIDTH +: WIDTH];
    assign y       = sel[1] ? pair_hi : pair_lo;

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one registered output slot between four valid/ready requesters.
module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       io_in_valid,
    input  logic [NUM_REQ*WIDTH-1:0] io_in_data,
    output logic [NUM_REQ-1:0]       io_in_ready,
    output logic                     io_out_valid,
    output logic [WIDTH-1:0]         io_out_data,
    input  logic                     io_out_ready,
    output logic [SEL_W-1:0]         io_selector,
    output logic [SEL_W-1:0]         io_grant_idx
);

    logic [SEL_W:0]   pick_p0;
    logic             found_p0;
    logic             free_p0;
    logic             accept_p0;
    logic [WIDTH-1:0] mux_data_p0;

    logic [SEL_W-1:0] last_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] out_data_p1;
    logic [SEL_W-1:0] grant_idx_p1;

    // Stage p0: combinational grant, ready and data select
    assign pick_p0     = rr_pick(io_in_valid, last_p1);
    assign found_p0    = pick_p0[SEL_W];
    assign io_selector = pick_p0[SEL_W-1:0];
    assign free_p0     = !vld_p1 || io_out_ready;
    assign accept_p0   = free_p0 && found_p0;

    always_comb begin
        io_in_ready = '0;
        if (accept_p0) begin
            io_in_ready[io_selector] = 1'b1;
        end
    end

    mux4_w #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel  (io_selector),
        .data (io_in_data),
        .y    (mux_data_p0)
    );

    // Stage p1: output slot and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_p1      <= 2'd3;
            vld_p1       <= 1'b0;
            out_data_p1  <= '0;
            grant_idx_p1 <= '0;
        end else if (accept_p0) begin
            last_p1      <= io_selector;
            vld_p1       <= 1'b1;
            out_data_p1  <= mux_data_p0;
            grant_idx_p1 <= io_selector;
        end else if (vld_p1 && io_out_ready) begin
            vld_p1       <= 1'b0;
        end
    end

    assign io_out_valid = vld_p1;
    assign io_out_data  = out_data_p1;
    assign io_grant_idx = grant_idx_p1;

endmodule
